// File: rtl/i2c_master_sched.sv
// i2c_master_sched
//   Single-byte I2C bus master shared by NREQ local requesters. A round-robin
//   arbiter picks one requester while idle. The engine then runs START,
//   address + R/W, address ACK, one data byte (write or read), ACK/NACK, and
//   STOP. It drives an open-drain SCL/SDA pair.
//
//   Bit timing: each SCL bit is four quarters of DIV clk each.
//     Q0: SCL low, SDA set.
//     Q1/Q2: SCL released.
//     Q3: SCL low.
//   The master samples SDA at the end of Q1.
//
// Parameters
//   NREQ  number of requesters (>= 2)
//   DIV   clk cycles per quarter SCL period (>= 2)
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   req        per-requester request, held until its done
//   req_rw     per-requester direction, 0 = write, 1 = read
//   req_addr   per-requester 7-bit address, slice i = [7i+6:7i]
//   req_wdata  per-requester write byte, slice i = [8i+7:8i]
//   grant      one-hot owner of the current transaction, 0 when idle
//   done       1-cycle pulse at the end of a transaction
//   ack_err    valid with done: address or write-data NACK seen
//   rdata      read byte, valid with done, held until the next done
//   busy       high from grant through STOP
//   scl, sda   open-drain bus lines (drive 0 or release only)
//
// Build option
//   I2C_STRETCH_EN : in Q1, if SCL is released but reads low, the quarter
//                    counter holds until SCL reads high.
//                    Without it, SCL is never read.

module i2c_master_sched #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DIV  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_rw,
  input  logic [7*NREQ-1:0]   req_addr,
  input  logic [8*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]     grant,
  output logic                done,
  output logic                ack_err,
  output logic [7:0]          rdata,
  output logic                busy,
  inout  wire                 scl,
  inout  wire                 sda
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned QW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_WDATA,
    S_WACK,
    S_RDATA,
    S_MNACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      quarter_q, quarter_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            rw_q, rw_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            ack_err_q, ack_err_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            scl_low, sda_low;
  logic            sda_in;
  logic            stall, tick, line_active;

  logic            arb_found;
  logic [IW-1:0]   arb_idx;
  logic [IW:0]     arb_cand;
  logic            arb_rw;
  logic [6:0]      arb_addr;
  logic [7:0]      arb_wdata;

  // ---------------------------------------------------------------------------
  // Bus pins
  // ---------------------------------------------------------------------------
  assign scl    = scl_low ? 1'b0 : 1'bz;
  assign sda    = sda_low ? 1'b0 : 1'bz;
  assign sda_in = sda;

  assign line_active = (state_q != S_IDLE) && (state_q != S_DONE);

`ifdef I2C_STRETCH_EN
  logic scl_in;
  assign scl_in = scl;
  // SCL released by us yet still low: a slave is stretching the clock.
  assign stall  = line_active && (quarter_q == 2'd1) && !scl_low && !scl_in;
`else
  assign stall  = 1'b0;
`endif

  assign tick = (qcnt_q == QW'(DIV - 1)) && !stall;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first requester at or after rr_q
  // ---------------------------------------------------------------------------
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_cand = (IW+1)'(rr_q) + (IW+1)'(i);
      if (arb_cand >= (IW+1)'(NREQ)) begin
        arb_cand = arb_cand - (IW+1)'(NREQ);
      end
      if (!arb_found && req[arb_cand[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand[IW-1:0];
      end
    end
  end

  always_comb begin
    arb_rw    = 1'b0;
    arb_addr  = '0;
    arb_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IW'(k) == arb_idx) begin
        arb_rw    = req_rw[k];
        arb_addr  = req_addr[7*k +: 7];
        arb_wdata = req_wdata[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM and quarter timebase
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;

    if (line_active) begin
      if (tick) begin
        qcnt_d    = '0;
        quarter_d = quarter_q + 2'd1;
      end else if (!stall) begin
        qcnt_d = qcnt_q + QW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        qcnt_d    = '0;
        quarter_d = '0;
        if (arb_found) begin
          state_d   = S_START;
          grant_d   = NREQ'(1) << arb_idx;
          gidx_d    = arb_idx;
          rw_d      = arb_rw;
          shift_d   = {arb_addr, arb_rw};
          wdata_d   = arb_wdata;
          ack_err_d = 1'b0;
          bitcnt_d  = '0;
        end
      end

      // START lasts two quarters; the first address bit starts at Q0.
      S_START: begin
        if (tick && quarter_q == 2'd1) begin
          state_d   = S_ADDR;
          quarter_d = '0;
        end
      end

      S_ADDR, S_WDATA: begin
        if (tick && quarter_q == 2'd3) begin
          shift_d  = {shift_q[6:0], 1'b0};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
          end
        end
      end

      S_AACK: begin
        if (tick && quarter_q == 2'd1 && sda_in) begin
          ack_err_d = 1'b1;
        end
        if (tick && quarter_q == 2'd3) begin
          bitcnt_d = '0;
          if (ack_err_q) begin
            state_d = S_STOP;
          end else if (rw_q) begin
            state_d = S_RDATA;
          end else begin
            state_d = S_WDATA;
            shift_d = wdata_q;
          end
        end
      end

      S_WACK: begin
        if (tick && quarter_q == 2'd1 && sda_in) begin
          ack_err_d = 1'b1;
        end
        if (tick && quarter_q == 2'd3) begin
          state_d = S_STOP;
        end
      end

      S_RDATA: begin
        if (tick && quarter_q == 2'd1) begin
          shift_d = {shift_q[6:0], sda_in};
        end
        if (tick && quarter_q == 2'd3) begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = S_MNACK;
          end
        end
      end

      S_MNACK: begin
        if (tick && quarter_q == 2'd3) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (tick && quarter_q == 2'd3) begin
          state_d = S_DONE;
          grant_d = '0;
          if (rw_q && !ack_err_q) begin
            rdata_d = shift_q;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        rr_d    = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line drive decode
  // ---------------------------------------------------------------------------
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state_q)
      S_START: begin
        sda_low = (quarter_q == 2'd1);
      end
      S_ADDR, S_WDATA: begin
        scl_low = (quarter_q == 2'd0) || (quarter_q == 2'd3);
        sda_low = ~shift_q[7];
      end
      S_AACK, S_WACK, S_RDATA, S_MNACK: begin
        scl_low = (quarter_q == 2'd0) || (quarter_q == 2'd3);
      end
      S_STOP: begin
        scl_low = (quarter_q == 2'd0);
        sda_low = (quarter_q <= 2'd1);
      end
      default: begin
        scl_low = 1'b0;
        sda_low = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      quarter_q <= '0;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_q      <= '0;
      ack_err_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_q      <= rr_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = |grant_q;
  assign done    = (state_q == S_DONE);
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_sched.sv
// Directed bench for i2c_master_sched with a behavioural I2C slave.
// The slave answers address 0x2A, returns 0xCC on reads, and stores written
// bytes in slave_dataout.

module tb_i2c_master_sched;

  localparam int unsigned NREQ      = 2;
  localparam int unsigned DIV       = 4;
  localparam int unsigned TXN_CLKS  = 78 * DIV;  // START + 18 bits + STOP
  localparam int unsigned NACK_CLKS = 42 * DIV;  // START + 9 bits + STOP
  localparam logic [6:0]  SLV_ADDR  = 7'h2A;
  localparam logic [7:0]  SLV_RDATA = 8'hCC;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req, req_rw;
  logic [7*NREQ-1:0]    req_addr;
  logic [8*NREQ-1:0]    req_wdata;
  logic [NREQ-1:0]      grant;
  logic                 done, ack_err, busy;
  logic [7:0]           rdata;
  wire                  scl, sda;

  logic tb_scl_low  = 1'b0;
  logic slv_sda_low = 1'b0;

  pullup (scl);
  pullup (sda);
  assign scl = tb_scl_low  ? 1'b0 : 1'bz;
  assign sda = slv_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_sched #(.NREQ(NREQ), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .ack_err   (ack_err),
    .rdata     (rdata),
    .busy      (busy),
    .scl       (scl),
    .sda       (sda)
  );

  // ---------------------------------------------------------------------------
  // Behavioural slave: samples on SCL rise, drives on SCL fall
  // ---------------------------------------------------------------------------
  logic        p_scl = 1'b1, p_sda = 1'b1;
  logic        s_active = 1'b0, s_match = 1'b0, s_rw = 1'b0, s_mack = 1'b0;
  logic [7:0]  s_sh = '0;
  logic [7:0]  rd_byte = SLV_RDATA;
  logic [7:0]  slave_dataout = '0;
  int unsigned s_cnt = 0, n_sclpos = 0, n_stop = 0, done_cnt = 0;

  always @(scl or sda) begin
    if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
      s_active    = 1'b1;
      s_cnt       = 0;
      s_sh        = '0;
      s_match     = 1'b0;
      slv_sda_low = 1'b0;
      n_sclpos    = 0;
    end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
      if (s_active) n_stop++;
      s_active    = 1'b0;
      slv_sda_low = 1'b0;
    end else if (p_scl === 1'b0 && scl === 1'b1 && s_active) begin
      s_cnt++;
      n_sclpos++;
      if ((s_cnt >= 1 && s_cnt <= 8) || (s_cnt >= 10 && s_cnt <= 17)) s_sh = {s_sh[6:0], sda};
      if (s_cnt == 18) s_mack = sda;
    end else if (p_scl === 1'b1 && scl === 1'b0 && s_active) begin
      if (s_cnt == 8) begin
        s_match     = (s_sh[7:1] == SLV_ADDR);
        s_rw        = s_sh[0];
        slv_sda_low = s_match;
      end else if (s_cnt == 17) begin
        if (s_match && !s_rw) begin
          slave_dataout = s_sh;
          slv_sda_low   = 1'b1;
        end else begin
          slv_sda_low = 1'b0;
        end
      end else if (s_match && s_rw && s_cnt >= 9 && s_cnt <= 16) begin
        slv_sda_low = ~rd_byte[16 - s_cnt];
      end else begin
        slv_sda_low = 1'b0;
      end
    end
    p_scl = scl;
    p_sda = sda;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int unsigned n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for busy, then for done, sampling 1 ns after each clock edge.
  task automatic run_wait(output logic [NREQ-1:0] g, output int unsigned gap,
                          output int unsigned cyc, output logic stable);
    gap = 0; cyc = 0; stable = 1'b1; g = '0;
    while (busy !== 1'b1 && gap < 200) begin
      @(posedge clk); #1; gap++;
    end
    check("busy_seen", {31'd0, busy}, 32'd1);
    g = grant;
    while (done !== 1'b1 && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
      if (done !== 1'b1 && grant !== g) stable = 1'b0;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    int unsigned     gap, cyc, st0, d0;
    logic            st;

    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant",   {30'd0, grant}, 32'd0);
    check("rst_busy",    {31'd0, busy},  32'd0);
    check("rst_done",    {31'd0, done},  32'd0);
    check("rst_ackerr",  {31'd0, ack_err}, 32'd0);
    check("rst_rdata",   {24'd0, rdata}, 32'd0);
    check("rst_scl",     {31'd0, scl},   32'd1);
    check("rst_sda",     {31'd0, sda},   32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: write 0xA5 to 0x2A from requester 0
    req_rw[0] = 1'b0; req_addr[6:0] = 7'h2A; req_wdata[7:0] = 8'hA5;
    st0 = n_stop; d0 = done_cnt;
    req[0] = 1'b1;
    run_wait(g, gap, cyc, st);
    req = '0;
    check("t1_grant",    {30'd0, g}, 32'h1);
    check("t1_gap",      gap, 32'd1);
    check("t1_cycles",   cyc, TXN_CLKS);
    check("t1_stable",   {31'd0, st}, 32'd1);
    check("t1_ackerr",   {31'd0, ack_err}, 32'd0);
    check("t1_busy",     {31'd0, busy}, 32'd0);
    check("t1_grant_done", {30'd0, grant}, 32'd0);
    check("t1_slave",    {24'd0, slave_dataout}, 32'hA5);
    check("t1_sclpos",   n_sclpos, 32'd19);
    check("t1_stop",     n_stop - st0, 32'd1);
    @(posedge clk); #1;
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_done_cnt", done_cnt - d0, 32'd1);

    // T2: read from 0x2A by requester 1 (rr pointer now at 1)
    req_rw[1] = 1'b1; req_addr[13:7] = 7'h2A; req_wdata[15:8] = 8'h00;
    st0 = n_stop;
    req[1] = 1'b1;
    run_wait(g, gap, cyc, st);
    req = '0;
    check("t2_grant",  {30'd0, g}, 32'h2);
    check("t2_rdata",  {24'd0, rdata}, 32'hCC);
    check("t2_ackerr", {31'd0, ack_err}, 32'd0);
    check("t2_mnack",  {31'd0, s_mack}, 32'd1);
    check("t2_stop",   n_stop - st0, 32'd1);
    check("t2_cycles", cyc, TXN_CLKS);
    check("t2_stable", {31'd0, st}, 32'd1);
    @(posedge clk); #1;

    // T3: address 0x15 is not answered
    req_rw[0] = 1'b0; req_addr[6:0] = 7'h15; req_wdata[7:0] = 8'h5A;
    req[0] = 1'b1;
    run_wait(g, gap, cyc, st);
    req = '0;
    check("t3_grant",  {30'd0, g}, 32'h1);
    check("t3_ackerr", {31'd0, ack_err}, 32'd1);
    check("t3_cycles", cyc, NACK_CLKS);
    check("t3_sclpos", n_sclpos, 32'd10);
    check("t3_slave",  {24'd0, slave_dataout}, 32'hA5);
    check("t3_rdata",  {24'd0, rdata}, 32'hCC);
    @(posedge clk); #1;

    // T4: both requesters held across four transactions
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
    req_rw = 2'b10; req_addr = {7'h2A, 7'h2A}; req_wdata = {8'h00, 8'h3C};
    d0 = done_cnt;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      run_wait(g, gap, cyc, st);
      check("t4_grant",  {30'd0, g}, (k % 2 == 0) ? 32'h1 : 32'h2);
      check("t4_gap",    gap, (k == 0) ? 32'd1 : 32'd2);
      check("t4_cycles", cyc, TXN_CLKS);
    end
    req = '0;
    @(posedge clk); #1;
    check("t4_done_cnt", done_cnt - d0, 32'd4);
    check("t4_slave",    {24'd0, slave_dataout}, 32'h3C);
    check("t4_rdata",    {24'd0, rdata}, 32'hCC);

    // T5: reset in the middle of the address phase
    req_rw[0] = 1'b0; req_wdata[7:0] = 8'h77;
    req[0] = 1'b1;
    gap = 0;
    while (busy !== 1'b1 && gap < 200) begin @(posedge clk); #1; gap++; end
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_scl",    {31'd0, scl},   32'd1);
    check("t5_sda",    {31'd0, sda},   32'd1);
    check("t5_grant",  {30'd0, grant}, 32'd0);
    check("t5_busy",   {31'd0, busy},  32'd0);
    check("t5_rdata",  {24'd0, rdata}, 32'd0);
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req[0] = 1'b1;
    run_wait(g, gap, cyc, st);
    req = '0;
    check("t5_re_grant",  {30'd0, g}, 32'h1);
    check("t5_re_cycles", cyc, TXN_CLKS);
    check("t5_re_slave",  {24'd0, slave_dataout}, 32'h77);
    check("t5_re_ackerr", {31'd0, ack_err}, 32'd0);
    @(posedge clk); #1;

`ifdef I2C_STRETCH_EN
    // T6: slave holds SCL low for 50 clk from the fall ending the second bit
    req_wdata[7:0] = 8'hA5;
    req[0] = 1'b1;
    fork
      run_wait(g, gap, cyc, st);
      begin : stretch
        int unsigned w;
        w = 0;
        while (busy !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
        if (busy === 1'b1) begin
          repeat (36) @(posedge clk);
          tb_scl_low = 1'b1;
          repeat (50) @(posedge clk);
          #1 tb_scl_low = 1'b0;
        end
      end
    join
    req = '0;
    check("t6_cycles", cyc, TXN_CLKS + 42);
    check("t6_slave",  {24'd0, slave_dataout}, 32'hA5);
    check("t6_ackerr", {31'd0, ack_err}, 32'd0);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
